// File: rtl/mac_accumulator_if.sv
// Handshake bundle for mac_accumulator: beat input channel and result output channel.
// Data buses are plain vectors; the unit interprets them as two's-complement internally.
interface mac_accumulator_if #(
  parameter int W_BITS   = 32,
  parameter int X_BITS   = 33,
  parameter int ACC_BITS = 64,
  parameter int CNT_BITS = 16
);
  logic                in_valid;
  logic                in_ready;
  logic [W_BITS-1:0]   w;
  logic [X_BITS-1:0]   x;
  logic                in_first;
  logic                in_last;
  logic [ACC_BITS-1:0] bias;
  logic                out_valid;
  logic                out_ready;
  logic [ACC_BITS-1:0] acc_out;
  logic                out_overflow;
  logic [CNT_BITS-1:0] out_count;

  modport master (
    output in_valid, w, x, in_first, in_last, bias, out_ready,
    input  in_ready, out_valid, acc_out, out_overflow, out_count
  );

  modport slave (
    input  in_valid, w, x, in_first, in_last, bias, out_ready,
    output in_ready, out_valid, acc_out, out_overflow, out_count
  );
endinterface

// File: rtl/mac_accumulator.sv
// Pipelined signed multiply-accumulate: PIPE product stages, one accumulate stage,
// one result register; the whole datapath freezes while a result waits for out_ready.
module mac_accumulator #(
  parameter int W_BITS   = 32,
  parameter int X_BITS   = 33,
  parameter int ACC_BITS = 64,
  parameter int PIPE     = 2,
  parameter bit SAT_EN   = 1'b1,
  parameter int CNT_BITS = 16
) (
  input  logic             clk,
  input  logic             rstn,
  mac_accumulator_if.slave bus
);

  localparam int PW  = W_BITS + X_BITS;
  localparam int MSB = ACC_BITS - 1;

  typedef logic signed [ACC_BITS-1:0] acc_t;

  localparam acc_t ACC_MAX = {1'b0, {(ACC_BITS-1){1'b1}}};
  localparam acc_t ACC_MIN = {1'b1, {(ACC_BITS-1){1'b0}}};

  logic                 en;
  logic signed [PW-1:0] mul_full;
  acc_t                 mul_ext;

  logic [PIPE-1:0] vld_q, vld_d, first_q, first_d, last_q, last_d;
  acc_t            prod_q [PIPE];
  acc_t            prod_d [PIPE];
  acc_t            bias_q [PIPE];
  acc_t            bias_d [PIPE];

  acc_t                acc_q, acc_d, acc_base, acc_a, sum;
  logic [CNT_BITS-1:0] cnt_q, cnt_d, cnt_base;
  logic                ovf_q, ovf_d, ovf_base, add_ovf;
  logic                open_q, open_d, open_base;
  logic                emit_q, emit_d;

  logic                out_valid_q, out_valid_d;
  acc_t                out_acc_q, out_acc_d;
  logic                out_ovf_q, out_ovf_d;
  logic [CNT_BITS-1:0] out_cnt_q, out_cnt_d;

  assign en           = !(out_valid_q && !bus.out_ready);
  assign bus.in_ready = en;
  assign mul_full     = $signed(bus.w) * $signed(bus.x);
  assign mul_ext      = ACC_BITS'(mul_full);

  assign bus.out_valid    = out_valid_q;
  assign bus.acc_out      = out_acc_q;
  assign bus.out_overflow = out_ovf_q;
  assign bus.out_count    = out_cnt_q;

  // Multiplier pipeline: every stage carries its tags and bias alongside the product.
  always_comb begin
    vld_d   = vld_q;
    first_d = first_q;
    last_d  = last_q;
    prod_d  = prod_q;
    bias_d  = bias_q;
    if (en) begin
      vld_d[0]   = bus.in_valid;
      first_d[0] = bus.in_first;
      last_d[0]  = bus.in_last;
      prod_d[0]  = mul_ext;
      bias_d[0]  = $signed(bus.bias);
      for (int i = 1; i < PIPE; i++) begin
        vld_d[i]   = vld_q[i-1];
        first_d[i] = first_q[i-1];
        last_d[i]  = last_q[i-1];
        prod_d[i]  = prod_q[i-1];
        bias_d[i]  = bias_q[i-1];
      end
    end else begin
      vld_d = vld_q;
    end
  end

  // Accumulate stage; a just-emitted vector reads back as zero so the next beat starts clean.
  always_comb begin
    acc_base  = emit_q ? {ACC_BITS{1'b0}} : acc_q;
    cnt_base  = emit_q ? {CNT_BITS{1'b0}} : cnt_q;
    ovf_base  = emit_q ? 1'b0 : ovf_q;
    open_base = emit_q ? 1'b0 : open_q;
    acc_a     = first_q[PIPE-1] ? bias_q[PIPE-1] : acc_base;
    sum       = acc_a + prod_q[PIPE-1];
    add_ovf   = (acc_a[MSB] == prod_q[PIPE-1][MSB]) && (sum[MSB] != acc_a[MSB]);
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    open_d    = open_q;
    emit_d    = emit_q;
    if (en) begin
      if (vld_q[PIPE-1]) begin
        if (add_ovf && SAT_EN) begin
          acc_d = acc_a[MSB] ? ACC_MIN : ACC_MAX;
        end else begin
          acc_d = sum;
        end
        if (first_q[PIPE-1]) begin
          cnt_d = CNT_BITS'(1);
        end else if (&cnt_base) begin
          cnt_d = cnt_base;
        end else begin
          cnt_d = cnt_base + CNT_BITS'(1);
        end
        ovf_d  = (first_q[PIPE-1] ? 1'b0 : ovf_base) | add_ovf;
        open_d = !last_q[PIPE-1];
        emit_d = last_q[PIPE-1];
      end else begin
        acc_d  = acc_base;
        cnt_d  = cnt_base;
        ovf_d  = ovf_base;
        open_d = open_base;
        emit_d = 1'b0;
      end
    end else begin
      emit_d = emit_q;
    end
  end

  // Result register loads the finished vector; otherwise it holds until handshaken.
  always_comb begin
    out_valid_d = out_valid_q;
    out_acc_d   = out_acc_q;
    out_ovf_d   = out_ovf_q;
    out_cnt_d   = out_cnt_q;
    if (en) begin
      out_valid_d = emit_q;
      if (emit_q) begin
        out_acc_d = acc_q;
        out_ovf_d = ovf_q;
        out_cnt_d = cnt_q;
      end else begin
        out_acc_d = out_acc_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rstn) begin
      vld_q   <= {PIPE{1'b0}};
      first_q <= {PIPE{1'b0}};
      last_q  <= {PIPE{1'b0}};
      for (int i = 0; i < PIPE; i++) begin
        prod_q[i] <= {ACC_BITS{1'b0}};
        bias_q[i] <= {ACC_BITS{1'b0}};
      end
      acc_q       <= {ACC_BITS{1'b0}};
      cnt_q       <= {CNT_BITS{1'b0}};
      ovf_q       <= 1'b0;
      open_q      <= 1'b0;
      emit_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= {ACC_BITS{1'b0}};
      out_ovf_q   <= 1'b0;
      out_cnt_q   <= {CNT_BITS{1'b0}};
    end else begin
      vld_q       <= vld_d;
      first_q     <= first_d;
      last_q      <= last_d;
      prod_q      <= prod_d;
      bias_q      <= bias_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      open_q      <= open_d;
      emit_q      <= emit_d;
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
      out_ovf_q   <= out_ovf_d;
      out_cnt_q   <= out_cnt_d;
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Self-checking bench for mac_accumulator: reference-model scoreboard on the default
// instance plus directed literal checks, and two 48-bit instances for saturate/wrap.
module tb_mac_accumulator;

  localparam int       P_MAIN   = 2;
  localparam bit       SAT_MAIN = 1'b1;
  localparam logic signed [127:0] M_MAX  = (128'sd1 <<< 63) - 128'sd1;
  localparam logic signed [127:0] M_MIN  = -(128'sd1 <<< 63);
  localparam logic signed [127:0] M_SPAN = 128'sd1 <<< 64;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  mac_accumulator_if #(.W_BITS(32), .X_BITS(33), .ACC_BITS(64), .CNT_BITS(16)) ifm ();
  mac_accumulator_if #(.W_BITS(16), .X_BITS(17), .ACC_BITS(48), .CNT_BITS(16)) ifs ();
  mac_accumulator_if #(.W_BITS(16), .X_BITS(17), .ACC_BITS(48), .CNT_BITS(16)) ifw ();

  mac_accumulator #(.W_BITS(32), .X_BITS(33), .ACC_BITS(64), .PIPE(P_MAIN),
                    .SAT_EN(SAT_MAIN), .CNT_BITS(16))
    u_dut (.clk(clk), .rstn(rstn), .bus(ifm));
  mac_accumulator #(.W_BITS(16), .X_BITS(17), .ACC_BITS(48), .PIPE(1),
                    .SAT_EN(1'b1), .CNT_BITS(16))
    u_sat (.clk(clk), .rstn(rstn), .bus(ifs));
  mac_accumulator #(.W_BITS(16), .X_BITS(17), .ACC_BITS(48), .PIPE(4),
                    .SAT_EN(1'b0), .CNT_BITS(16))
    u_wrap (.clk(clk), .rstn(rstn), .bus(ifw));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: vector-level arithmetic on wide integers, results queued in order.
  typedef struct {
    logic [63:0] acc;
    logic [15:0] cnt;
    logic        ovf;
  } exp_t;

  exp_t               exp_q[$];
  logic signed [127:0] m_sum = 128'sd0;
  int                  m_cnt = 0;
  logic                m_ovf = 1'b0;

  task automatic model_beat(input logic [31:0] w, input logic [32:0] x,
                            input logic f, input logic l, input logic [63:0] b);
    logic signed [127:0] p, s;
    exp_t e;
    p = 128'($signed(w)) * 128'($signed(x));
    if (f) begin
      m_sum = 128'($signed(b));
      m_cnt = 0;
      m_ovf = 1'b0;
    end
    s = m_sum + p;
    if (s > M_MAX) begin
      m_ovf = 1'b1;
      s = SAT_MAIN ? M_MAX : s - M_SPAN;
    end else if (s < M_MIN) begin
      m_ovf = 1'b1;
      s = SAT_MAIN ? M_MIN : s + M_SPAN;
    end
    m_sum = s;
    m_cnt = (m_cnt == 65535) ? 65535 : m_cnt + 1;
    if (l) begin
      e.acc = s[63:0];
      e.cnt = 16'(m_cnt);
      e.ovf = m_ovf;
      exp_q.push_back(e);
      m_sum = 128'sd0;
      m_cnt = 0;
      m_ovf = 1'b0;
    end
  endtask

  // Compare process: checks every visible result against the model, feeds accepted beats.
  always @(negedge clk) begin
    if (ifm.out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: actual acc %0h, expected no result", ifm.acc_out);
      end else begin
        check("sb_acc", ifm.acc_out, exp_q[0].acc);
        check("sb_cnt", 64'(ifm.out_count), 64'(exp_q[0].cnt));
        check("sb_ovf", 64'(ifm.out_overflow), 64'(exp_q[0].ovf));
        if (ifm.out_ready) exp_q.pop_front();
      end
    end
    if (rstn) begin
      exp_q.delete();
      m_sum = 128'sd0;
      m_cnt = 0;
      m_ovf = 1'b0;
    end else if (ifm.in_valid && ifm.in_ready) begin
      model_beat(ifm.w, ifm.x, ifm.in_first, ifm.in_last, ifm.bias);
    end
  end

  logic [63:0] r_acc;
  logic [15:0] r_cnt;
  logic        r_ovf;
  int          r_lat;

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input logic [32:0] x, input logic f,
                      input logic l, input logic [63:0] b, output int waited);
    logic rdy;
    ifm.in_valid = 1'b1;
    ifm.w        = w;
    ifm.x        = x;
    ifm.in_first = f;
    ifm.in_last  = l;
    ifm.bias     = b;
    waited       = 0;
    rdy          = 1'b0;
    while (!rdy && waited < 60) begin
      @(negedge clk);
      rdy = ifm.in_ready;
      @(posedge clk);
      waited++;
    end
    #1;
    ifm.in_valid = 1'b0;
    if (!rdy) check("send_timeout", 64'(rdy), 64'd1);
  endtask

  task automatic wait_result();
    logic found;
    found = 1'b0;
    r_lat = 0;
    while (!found && r_lat < 40) begin
      @(posedge clk);
      #1;
      r_lat++;
      if (ifm.out_valid) begin
        found = 1'b1;
        r_acc = ifm.acc_out;
        r_cnt = ifm.out_count;
        r_ovf = ifm.out_overflow;
      end
    end
    check("result_seen", 64'(found), 64'd1);
  endtask

  int   wt;
  int   lat_s, lat_w, cyc;
  logic got_s, got_w;
  int   b2b_cnt, b2b_first, b2b_last;

  initial begin
    ifm.in_valid = 1'b0; ifm.w = '0; ifm.x = '0; ifm.in_first = 1'b0;
    ifm.in_last = 1'b0; ifm.bias = '0; ifm.out_ready = 1'b1;
    ifs.in_valid = 1'b0; ifs.w = '0; ifs.x = '0; ifs.in_first = 1'b0;
    ifs.in_last = 1'b0; ifs.bias = '0; ifs.out_ready = 1'b1;
    ifw.in_valid = 1'b0; ifw.w = '0; ifw.x = '0; ifw.in_first = 1'b0;
    ifw.in_last = 1'b0; ifw.bias = '0; ifw.out_ready = 1'b1;

    idle(3);
    rstn = 1'b0;
    check("rst_out_valid", 64'(ifm.out_valid), 64'd0);
    check("rst_acc_out", ifm.acc_out, 64'd0);
    check("rst_count", 64'(ifm.out_count), 64'd0);
    check("rst_overflow", 64'(ifm.out_overflow), 64'd0);
    check("rst_in_ready", 64'(ifm.in_ready), 64'd1);

    // 48-bit saturate (PIPE=1) and wrap (PIPE=4): 2^47-10 + 1*100
    ifs.in_valid = 1'b1; ifs.in_first = 1'b1; ifs.in_last = 1'b1;
    ifs.w = 16'd1; ifs.x = 17'd100; ifs.bias = 48'h7FFF_FFFF_FFF6;
    ifw.in_valid = 1'b1; ifw.in_first = 1'b1; ifw.in_last = 1'b1;
    ifw.w = 16'd1; ifw.x = 17'd100; ifw.bias = 48'h7FFF_FFFF_FFF6;
    idle(1);
    ifs.in_valid = 1'b0;
    ifw.in_valid = 1'b0;
    got_s = 1'b0; got_w = 1'b0; lat_s = 0; lat_w = 0; cyc = 0;
    while (!(got_s && got_w) && cyc < 20) begin
      idle(1);
      cyc++;
      if (ifs.out_valid && !got_s) begin
        got_s = 1'b1; lat_s = cyc;
        check("sat_acc", 64'(ifs.acc_out), 64'h0000_7FFF_FFFF_FFFF);
        check("sat_ovf", 64'(ifs.out_overflow), 64'd1);
        check("sat_cnt", 64'(ifs.out_count), 64'd1);
      end
      if (ifw.out_valid && !got_w) begin
        got_w = 1'b1; lat_w = cyc;
        check("wrap_acc", 64'(ifw.acc_out), 64'h0000_8000_0000_005A);
        check("wrap_ovf", 64'(ifw.out_overflow), 64'd1);
        check("wrap_cnt", 64'(ifw.out_count), 64'd1);
      end
    end
    check("sat_latency", 64'(lat_s), 64'd2);
    check("wrap_latency", 64'(lat_w), 64'd5);

    // Basic dot product 10 + 3*4 - 2*7 + 5*(-1) = 3
    send(32'd3, 33'd4, 1'b1, 1'b0, 64'd10, wt);
    send(-32'sd2, 33'd7, 1'b0, 1'b0, 64'd0, wt);
    send(32'd5, -33'sd1, 1'b0, 1'b1, 64'd0, wt);
    wait_result();
    check("t1_latency", 64'(r_lat), 64'(P_MAIN + 1));
    check("t1_acc", r_acc, 64'd3);
    check("t1_cnt", 64'(r_cnt), 64'd3);
    check("t1_ovf", 64'(r_ovf), 64'd0);
    idle(3);

    send(-32'sd1, 33'h1_0000_0000, 1'b1, 1'b1, 64'd0, wt);
    wait_result();
    check("t2_acc", r_acc, 64'h0000_0001_0000_0000);
    check("t2_cnt", 64'(r_cnt), 64'd1);
    idle(3);

    // Negative clamp, then accumulation continues from the clamped value
    send(-32'sd3, 33'd4, 1'b1, 1'b0, 64'h8000_0000_0000_0005, wt);
    send(32'd1, 33'd100, 1'b0, 1'b1, 64'd0, wt);
    wait_result();
    check("t3_acc", r_acc, 64'h8000_0000_0000_0064);
    check("t3_cnt", 64'(r_cnt), 64'd2);
    check("t3_ovf", 64'(r_ovf), 64'd1);
    idle(3);

    // Restarted vector drops its partial sum; orphan beat accumulates onto zero
    send(32'd1, 33'd1, 1'b1, 1'b0, 64'd50, wt);
    send(32'd9, 33'd9, 1'b0, 1'b0, 64'd0, wt);
    send(32'd4, 33'd4, 1'b1, 1'b0, 64'd0, wt);
    send(32'd1, 33'd1, 1'b0, 1'b1, 64'd0, wt);
    wait_result();
    check("t4_acc", r_acc, 64'd17);
    check("t4_cnt", 64'(r_cnt), 64'd2);
    idle(3);
    send(32'd2, 33'd5, 1'b0, 1'b1, 64'd77, wt);
    wait_result();
    check("t4b_acc", r_acc, 64'd10);
    check("t4b_cnt", 64'(r_cnt), 64'd1);
    idle(3);

    // Output stall with continuous input
    ifm.out_ready = 1'b0;
    fork
      begin
        send(32'd2, 33'd3, 1'b1, 1'b1, 64'd0, wt);
        send(32'd1, 33'd1, 1'b1, 1'b0, 64'd100, wt);
        send(32'd1, 33'd2, 1'b0, 1'b0, 64'd0, wt);
        send(32'd1, 33'd3, 1'b0, 1'b0, 64'd0, wt);
        send(32'd1, 33'd4, 1'b0, 1'b0, 64'd0, wt);
        send(32'd1, 33'd5, 1'b0, 1'b1, 64'd0, wt);
      end
      begin
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
          idle(1);
          seen = ifm.out_valid;
        end
        check("stall_seen", 64'(seen), 64'd1);
        for (int i = 0; i < 5; i++) begin
          check("stall_in_ready", 64'(ifm.in_ready), 64'd0);
          check("stall_valid", 64'(ifm.out_valid), 64'd1);
          check("stall_acc", ifm.acc_out, 64'd6);
          idle(1);
        end
        ifm.out_ready = 1'b1;
      end
    join
    wait_result();
    check("t5_acc", r_acc, 64'd115);
    check("t5_cnt", 64'(r_cnt), 64'd5);
    check("t5_latency", 64'(r_lat), 64'(P_MAIN + 1));
    idle(3);

    // Back-to-back single-beat vectors
    b2b_cnt = 0; b2b_first = -1; b2b_last = -1;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send(32'(i + 1), 33'(i + 2), 1'b1, 1'b1, 64'(i), wt);
          check("b2b_waited", 64'(wt), 64'd1);
        end
      end
      begin
        for (int i = 0; i < 16; i++) begin
          idle(1);
          if (ifm.out_valid) begin
            b2b_cnt++;
            if (b2b_first < 0) b2b_first = i;
            b2b_last = i;
          end
        end
      end
    join
    check("b2b_results", 64'(b2b_cnt), 64'd6);
    check("b2b_span", 64'(b2b_last - b2b_first), 64'd5);
    idle(3);

    // Reset mid-vector discards in-flight beats
    send(32'd5, 33'd5, 1'b1, 1'b0, 64'd3, wt);
    send(32'd6, 33'd6, 1'b0, 1'b0, 64'd0, wt);
    rstn = 1'b1;
    idle(1);
    rstn = 1'b0;
    send(32'd2, 33'd3, 1'b1, 1'b1, 64'd1, wt);
    wait_result();
    check("t7_acc", r_acc, 64'd7);
    check("t7_cnt", 64'(r_cnt), 64'd1);
    check("t7_latency", 64'(r_lat), 64'(P_MAIN + 1));
    idle(6);
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
